// File: rtl/controle_senha_pkg.sv
// Shared definitions for the password-guessing game control stage.
package controle_senha_pkg;

  localparam int unsigned SenhaW = 7;
  localparam int unsigned RestW  = 4;
  localparam logic [SenhaW-1:0] SeedDefault = 7'h5A;

  typedef enum logic [1:0] {
    Ocioso  = 2'd0,
    Aguarda = 2'd1,
    Compara = 2'd2,
    Fim     = 2'd3
  } estado_t;

  // Fibonacci step for x^7 + x^6 + 1 (taps at bits 6 and 5)
  function automatic logic [SenhaW-1:0] lfsr_next(input logic [SenhaW-1:0] v);
    return {v[SenhaW-2:0], v[6] ^ v[5]};
  endfunction

  // An all-zero seed would lock the LFSR, so substitute 1
  function automatic logic [SenhaW-1:0] seed_valida(input logic [SenhaW-1:0] s);
    return (s == '0) ? SenhaW'(1) : s;
  endfunction

endpackage

// File: rtl/controle_senha_lfsr7.sv
// Free-running 7-bit maximal-length LFSR; output is never zero.
module controle_senha_lfsr7
  import controle_senha_pkg::*;
#(
  parameter logic [SenhaW-1:0] SEED = SeedDefault
) (
  input  logic              clk,
  input  logic              reset,
  output logic [SenhaW-1:0] valor
);

  localparam logic [SenhaW-1:0] SeedEff = seed_valida(SEED);

  logic [SenhaW-1:0] lfsr_q;

  // Shift every cycle regardless of game state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SeedEff;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign valor = lfsr_q;

endmodule

// File: rtl/controle_senha.sv
// Game control: password generation, guess capture/compare, attempt tracking.
module controle_senha
  import controle_senha_pkg::*;
#(
  parameter int unsigned       MAX_TENTATIVAS = 8,
  parameter logic [SenhaW-1:0] LFSR_SEED      = SeedDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              confirmar,
  input  logic [SenhaW-1:0] chave,
  output logic [SenhaW-1:0] senha_oculta,
  output logic [SenhaW-1:0] tentativa,
  output logic [SenhaW-1:0] cont,
  output logic              set,
  output logic              acertou,
  output logic              perdeu,
  output logic [RestW-1:0]  restantes
);

  localparam logic [RestW-1:0] MaxRest = MAX_TENTATIVAS[RestW-1:0];

  estado_t           estado_q, estado_d;
  logic [SenhaW-1:0] senha_q, senha_d;
  logic [SenhaW-1:0] tent_q, tent_d;
  logic [SenhaW-1:0] cont_q;
  logic              set_q, set_d;
  logic              acertou_q, acertou_d;
  logic              perdeu_q, perdeu_d;
  logic [RestW-1:0]  rest_q, rest_d;
  logic              ini_hist_q, conf_hist_q;
  logic              ini_ev, conf_ev;
  logic [RestW-1:0]  rest_dec;
  logic [SenhaW-1:0] lfsr_val;

  controle_senha_lfsr7 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .valor (lfsr_val)
  );

  assign ini_ev   = iniciar & ~ini_hist_q;
  assign conf_ev  = confirmar & ~conf_hist_q;
  assign rest_dec = rest_q - 1'b1;

  // Next-state and output-register logic for the game FSM
  always_comb begin
    estado_d  = estado_q;
    senha_d   = senha_q;
    tent_d    = tent_q;
    set_d     = 1'b0;
    acertou_d = acertou_q;
    perdeu_d  = perdeu_q;
    rest_d    = rest_q;

    // A start request wins everywhere except mid-compare, where it is dropped
    if (ini_ev && (estado_q != Compara)) begin
      senha_d   = lfsr_val;
      rest_d    = MaxRest;
      acertou_d = 1'b0;
      perdeu_d  = 1'b0;
      estado_d  = Aguarda;
    end else begin
      case (estado_q)
        Aguarda: begin
          if (conf_ev) begin
            tent_d   = chave;
            estado_d = Compara;
          end
        end
        Compara: begin
          if (tent_q == senha_q) begin
            acertou_d = 1'b1;
            estado_d  = Fim;
          end else begin
            // Losing guess still pulses set so its hint is shown
            set_d  = 1'b1;
            rest_d = rest_dec;
            if (rest_dec == '0) begin
              perdeu_d = 1'b1;
              estado_d = Fim;
            end else begin
              estado_d = Aguarda;
            end
          end
        end
        Ocioso, Fim: begin
          estado_d = estado_q;
        end
        default: begin
          estado_d = Ocioso;
        end
      endcase
    end
  end

  // State, output registers, edge history and free-running counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q    <= Ocioso;
      senha_q     <= '0;
      tent_q      <= '0;
      cont_q      <= '0;
      set_q       <= 1'b0;
      acertou_q   <= 1'b0;
      perdeu_q    <= 1'b0;
      rest_q      <= '0;
      ini_hist_q  <= 1'b0;
      conf_hist_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      senha_q     <= senha_d;
      tent_q      <= tent_d;
      cont_q      <= cont_q + 1'b1;
      set_q       <= set_d;
      acertou_q   <= acertou_d;
      perdeu_q    <= perdeu_d;
      rest_q      <= rest_d;
      ini_hist_q  <= iniciar;
      conf_hist_q <= confirmar;
    end
  end

  assign senha_oculta = senha_q;
  assign tentativa    = tent_q;
  assign cont         = cont_q;
  assign set          = set_q;
  assign acertou      = acertou_q;
  assign perdeu       = perdeu_q;
  assign restantes    = rest_q;

endmodule

// File: tb/tb_controle_senha.sv
// Self-checking bench for controle_senha with a transaction-level game model.
module tb_controle_senha;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       confirmar = 1'b0;
  logic [6:0] chave = '0;

  logic [6:0] senha_a, tent_a, cont_a;
  logic       set_a, acertou_a, perdeu_a;
  logic [3:0] rest_a;
  logic [6:0] senha_b, tent_b, cont_b;
  logic       set_b, acertou_b, perdeu_b;
  logic [3:0] rest_b;

  controle_senha dut_a (
    .clk (clk), .reset (reset), .iniciar (iniciar), .confirmar (confirmar), .chave (chave),
    .senha_oculta (senha_a), .tentativa (tent_a), .cont (cont_a), .set (set_a),
    .acertou (acertou_a), .perdeu (perdeu_a), .restantes (rest_a)
  );

  controle_senha #(
    .MAX_TENTATIVAS (3),
    .LFSR_SEED      (7'h00)
  ) dut_b (
    .clk (clk), .reset (reset), .iniciar (iniciar), .confirmar (confirmar), .chave (chave),
    .senha_oculta (senha_b), .tentativa (tent_b), .cont (cont_b), .set (set_b),
    .acertou (acertou_b), .perdeu (perdeu_b), .restantes (rest_b)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release
  int edges;
  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else        edges <= edges + 1;
  end

  int checks = 0;
  int errors = 0;

  // Model of dut_a game state
  logic [6:0] ma_senha, ma_tent;
  logic [3:0] ma_rest;
  logic       ma_win, ma_lose, ma_active;

  // Password sequence: LFSR for x^7+x^6+1 advanced n times from the effective seed
  function automatic logic [6:0] lfsr_at(input logic [6:0] seed, input int n);
    logic [6:0] v;
    v = (seed == 7'h00) ? 7'h01 : seed;
    for (int i = 0; i < (n % 127); i++) v = {v[5:0], v[6] ^ v[5]};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; iniciar = 1'b0; confirmar = 1'b0;
    ma_senha = '0; ma_tent = '0; ma_rest = '0;
    ma_win = 1'b0; ma_lose = 1'b0; ma_active = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_a();
    int n0;
    n0 = edges;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    ma_senha = lfsr_at(7'h5A, n0);
    ma_rest = 4'd8; ma_win = 1'b0; ma_lose = 1'b0; ma_active = 1'b1;
    checks++;
    if (senha_a !== ma_senha || rest_a !== 4'd8) begin
      errors++;
      $display("FAIL start: senha %0h rest %0d, expected senha %0h rest 8", senha_a, rest_a, ma_senha);
    end
  endtask

  task automatic guess_a(input logic [6:0] g);
    logic exp_set;
    chave = g;
    confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    exp_set = 1'b0;
    if (ma_active) begin
      ma_tent = g;
      if (g == ma_senha) begin
        ma_win = 1'b1; ma_active = 1'b0;
      end else begin
        exp_set = 1'b1;
        ma_rest = ma_rest - 4'd1;
        if (ma_rest == 4'd0) begin ma_lose = 1'b1; ma_active = 1'b0; end
      end
    end
    checks++;
    if (tent_a !== ma_tent) begin
      errors++;
      $display("FAIL guess_capture: tentativa %0h expected %0h", tent_a, ma_tent);
    end
    tick();
    checks++;
    if (set_a !== exp_set || acertou_a !== ma_win || perdeu_a !== ma_lose ||
        rest_a !== ma_rest || tent_a !== ma_tent) begin
      errors++;
      $display("FAIL guess_result: set %b win %b lose %b rest %0d tent %0h, expected %b %b %b %0d %0h",
               set_a, acertou_a, perdeu_a, rest_a, tent_a, exp_set, ma_win, ma_lose, ma_rest,
               ma_tent);
    end
    tick();
    checks++;
    if (set_a !== 1'b0) begin
      errors++;
      $display("FAIL set_single: set %b expected 0", set_a);
    end
  endtask

  function automatic logic [6:0] wrong_for(input logic [6:0] s1, input logic [6:0] s2);
    logic [6:0] g;
    g = 7'($urandom);
    while (g == s1 || g == s2) g = g + 7'd1;
    return g;
  endfunction

  task automatic test_reset();
    do_reset();
    start_a();
    for (int i = 0; i < 3; i++) guess_a(wrong_for(ma_senha, ma_senha));
    checks++;
    if (rest_a !== 4'd5) begin
      errors++;
      $display("FAIL reset_setup: rest %0d expected 5", rest_a);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({senha_a, tent_a, cont_a, set_a, acertou_a, perdeu_a, rest_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: senha %0h tent %0h cont %0h set %b win %b lose %b rest %0d, expected all 0",
               senha_a, tent_a, cont_a, set_a, acertou_a, perdeu_a, rest_a);
    end
    @(negedge clk);
    reset = 1'b1;
    ma_senha = '0; ma_tent = '0; ma_rest = '0;
    ma_win = 1'b0; ma_lose = 1'b0; ma_active = 1'b0;
    for (int i = 0; i < 10; i++) begin
      confirmar = i[0];
      chave = 7'($urandom);
      tick();
      checks++;
      if (set_a !== 1'b0 || rest_a !== 4'd0 || tent_a !== 7'd0) begin
        errors++;
        $display("FAIL reset_idle: set %b rest %0d tent %0h, expected 0 0 0", set_a, rest_a, tent_a);
      end
    end
    confirmar = 1'b0;
    tick();
  endtask

  task automatic test_win();
    do_reset();
    repeat ($urandom_range(0, 9)) tick();
    start_a();
    guess_a(ma_senha);
    checks++;
    if (acertou_a !== 1'b1 || rest_a !== 4'd8) begin
      errors++;
      $display("FAIL win: acertou %b rest %0d, expected 1 8", acertou_a, rest_a);
    end
    start_a();
    guess_a(wrong_for(ma_senha, ma_senha));
    guess_a(ma_senha);
    guess_a(wrong_for(ma_senha, ma_senha));
  endtask

  task automatic test_loss();
    logic [6:0] g, sb, last;
    int n0;
    do_reset();
    n0 = edges;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    sb = lfsr_at(7'h00, n0);
    last = '0;
    for (int i = 0; i < 3; i++) begin
      g = wrong_for(sb, sb);
      last = g;
      chave = g; confirmar = 1'b1; tick(); confirmar = 1'b0; tick();
      checks++;
      if (set_b !== 1'b1 || rest_b !== 4'(2 - i) || perdeu_b !== (i == 2) || acertou_b !== 1'b0) begin
        errors++;
        $display("FAIL loss_step%0d: set %b rest %0d perdeu %b, expected 1 %0d %b",
                 i, set_b, rest_b, perdeu_b, 2 - i, i == 2);
      end
      tick();
      checks++;
      if (set_b !== 1'b0) begin
        errors++;
        $display("FAIL loss_pulse%0d: set %b expected 0", i, set_b);
      end
    end
    chave = ~last; confirmar = 1'b1; tick(); confirmar = 1'b0; tick();
    checks++;
    if (tent_b !== last || set_b !== 1'b0 || perdeu_b !== 1'b1 || rest_b !== 4'd0) begin
      errors++;
      $display("FAIL loss_ignored: tent %0h set %b perdeu %b rest %0d, expected %0h 0 1 0",
               tent_b, set_b, perdeu_b, rest_b, last);
    end
  endtask

  task automatic test_held();
    int pulses;
    logic prev;
    do_reset();
    start_a();
    chave = wrong_for(ma_senha, ma_senha);
    confirmar = 1'b1;
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (set_a) pulses++;
      checks++;
      if (set_a && prev) begin
        errors++;
        $display("FAIL held_consecutive: set high two cycles, expected single pulse");
      end
      prev = set_a;
    end
    confirmar = 1'b0;
    tick();
    checks++;
    if (pulses != 1 || rest_a !== 4'd7) begin
      errors++;
      $display("FAIL held: pulses %0d rest %0d, expected 1 7", pulses, rest_a);
    end
  endtask

  task automatic test_simul();
    logic [6:0] g1, s_exp;
    int n0;
    do_reset();
    start_a();
    g1 = wrong_for(ma_senha, ma_senha);
    guess_a(g1);
    chave = ~g1;
    n0 = edges;
    iniciar = 1'b1; confirmar = 1'b1;
    tick();
    iniciar = 1'b0; confirmar = 1'b0;
    s_exp = lfsr_at(7'h5A, n0);
    checks++;
    if (tent_a !== g1 || rest_a !== 4'd8 || senha_a !== s_exp || senha_a === 7'd0) begin
      errors++;
      $display("FAIL simul: tent %0h rest %0d senha %0h, expected %0h 8 %0h",
               tent_a, rest_a, senha_a, g1, s_exp);
    end
    tick();
    checks++;
    if (set_a !== 1'b0 || tent_a !== g1) begin
      errors++;
      $display("FAIL simul_discard: set %b tent %0h, expected 0 %0h", set_a, tent_a, g1);
    end
  endtask

  task automatic test_lfsr();
    bit seen [128];
    int distinct;
    int n0;
    logic [6:0] e;
    do_reset();
    iniciar = 1'b1;
    tick();
    checks++;
    if (senha_b !== 7'h01) begin
      errors++;
      $display("FAIL lfsr_zero_seed: senha %0h expected 01", senha_b);
    end
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    for (int i = 0; i < 127; i++) begin
      iniciar = 1'b0;
      tick();
      n0 = edges;
      iniciar = 1'b1;
      tick();
      e = lfsr_at(7'h00, n0);
      checks++;
      if (senha_b !== e || senha_b === 7'd0) begin
        errors++;
        $display("FAIL lfsr_seq: senha %0h expected %0h at step %0d", senha_b, e, n0);
      end
      seen[senha_b] = 1'b1;
    end
    iniciar = 1'b0;
    distinct = 0;
    for (int i = 0; i < 128; i++) if (seen[i]) distinct++;
    checks++;
    if (distinct != 127 || seen[0]) begin
      errors++;
      $display("FAIL lfsr_period: distinct %0d zero %b, expected 127 0", distinct, seen[0]);
    end
  endtask

  task automatic test_cont();
    do_reset();
    while (edges < 127) tick();
    checks++;
    if (cont_a !== 7'd127) begin
      errors++;
      $display("FAIL cont_top: cont %0d expected 127", cont_a);
    end
    tick();
    checks++;
    if (cont_a !== 7'd0) begin
      errors++;
      $display("FAIL cont_wrap: cont %0d expected 0", cont_a);
    end
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 90)) tick();
      checks++;
      if (cont_a !== edges[6:0]) begin
        errors++;
        $display("FAIL cont_run: cont %0d expected %0d", cont_a, edges[6:0]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 5)) tick();
      start_a();
      for (int k = 0; k < 11; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 4) == 0) guess_a(ma_senha);
        else guess_a(7'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_loss();
    test_held();
    test_simul();
    test_lfsr();
    test_cont();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
